ddr_fifo_arbiter: RTL and testbench
===================================

# ddr_fifo_arbiter

Two-requester round-robin arbiter and transaction sequencer that sits in the 25 MHz `clk` domain in front of the DDR3 bridge's cache-side command/response FIFO port. It accepts whole read or write burst transactions from two cache clients (port 0, port 1) and serializes them into typed command beats: CMD for the first write beat, WT for subsequent write beats, and RD for a read. It routes read response beats back to the owning requester and holds the grant until the transaction completes, with only one transaction outstanding at a time.

## Interface
- ADDR_WIDTH, 27, DDR app address width
- BRST_WIDTH, 6, burst field width; beats = burst_cnt + 1 (1..64)
- DATA_WIDTH, 128, beat data width
- MASK_WIDTH, 16, byte mask width (passed through unmodified)
- clk  in  1  25 MHz system clock; all logic on posedge
- rstn  in  1  reset, asynchronous, active-low
- calib_done  in  1  DDR calibration complete; no grants while low
- sN_req_valid / sN_req_ready  in/out  1  transaction request handshake, N=0,1
- sN_req_write  in  1  1 = write, 0 = read
- sN_req_addr  in  ADDR_WIDTH  start address
- sN_req_burst  in  BRST_WIDTH  beats-1
- sN_wvalid / sN_wready  in/out  1  write beat handshake
- sN_wdata  in  DATA_WIDTH; sN_wmask  in  MASK_WIDTH
- sN_rvalid / sN_rready  out/in  1  read response handshake
- sN_rdata  out  DATA_WIDTH; sN_rlast  out  1  final read beat
- m_cmd_valid / m_cmd_ready  out/in  1  command FIFO push handshake
- m_cmd_type  out  2  0 IDLE, 1 CMD, 2 WT, 3 RD
- m_cmd_addr  out  ADDR_WIDTH; m_cmd_burst  out  BRST_WIDTH
- m_cmd_wdata  out  DATA_WIDTH; m_cmd_wmask  out  MASK_WIDTH
- m_rsp_valid / m_rsp_ready  in/out  1  response FIFO pop handshake
- m_rsp_data  in  DATA_WIDTH

## Operation
- States: IDLE, WR_BEAT, RD_CMD, RD_RSP. Registers: owner (1 b), prio (1 b), addr, burst, beat counter (BRST_WIDTH+1 b), state.
- IDLE: when calib_done=1, grant the valid requester. If both are valid, grant port prio. Only the granted port sees sN_req_ready=1, for exactly one cycle (combinational on valid & grant). On that handshake, latch owner/addr/burst, clear beat=0, and go to WR_BEAT (write) or RD_CMD (read).
- WR_BEAT: m_cmd_valid = s[owner]_wvalid and s[owner]_wready = m_cmd_ready; all other sN_wready=0. m_cmd_type = CMD when beat==0, else WT. m_cmd_addr/m_cmd_burst = latched values; wdata/wmask pass through from owner. Each fire increments beat. The fire with beat==burst returns to IDLE.
- RD_CMD: m_cmd_valid=1, type RD, latched addr/burst, wdata=0, wmask=all-ones. On fire, go to RD_RSP.
- RD_RSP: s[owner]_rvalid = m_rsp_valid, m_rsp_ready = s[owner]_rready, s[owner]_rdata = m_rsp_data, s[owner]_rlast = (beat==burst). Each fire increments beat. The fire with beat==burst returns to IDLE.
- On return to IDLE: prio <= ~owner (round-robin).
- Outside owned states: all sN_wready, sN_rvalid, sN_rlast = 0 and sN_rdata = 0. m_rsp_ready=0 except in RD_RSP, so stray response data is never popped.
- A requester may hold wvalid before its request is granted; no write beat is taken before the grant.
- calib_done falling mid-transaction does not abort; it only blocks new grants.

## Timing
- Reset values: state IDLE, prio 0, owner 0, beat 0. All valid/ready outputs 0, m_cmd_type 0, m_cmd_addr/burst/wdata 0, m_cmd_wmask all-ones, sN_rdata/rlast 0.
- Request accept at cycle T. First command beat is presentable at T+1. Next request is accept-able at the earliest one cycle after the final fire.
- Single-beat write: 2 cycles minimum (accept, CMD). Single-beat read: accept, RD, then response ≥ 1 cycle.
- Back-to-back write beats are at full rate (1 per cycle) when wvalid and m_cmd_ready are both held high.
- Reset asserted mid-transaction: immediate return to reset values. Partial bursts already pushed are not recovered; the bridge must be reset together with this block.
- Beat counter is BRST_WIDTH+1 bits wide, so burst=63 (64 beats) does not wrap before compare.

## Test plan
- Port 0 write, addr 0x100, burst 3, with m_cmd_ready=1 -> 4 beats typed 1,2,2,2, each with addr 0x100 and burst 3; s0_wready high for 4 cycles; back to IDLE; prio=1.
- Both ports request reads (burst 0) in the same cycle after reset -> port 0 granted first (one RD beat, one response routed to s0 with rlast=1), then port 1; s1 sees no rvalid during port 0's response.
- Port 1 read, burst 63, with m_rsp_valid toggling and s1_rready throttled -> exactly 64 beats delivered in order, rlast only on the 64th, and m_rsp_ready never high while s1_rready=0.
- calib_done=0 with s0_req_valid=1 for 10 cycles -> s0_req_ready stays 0; grant occurs the cycle after calib_done rises.
- m_cmd_ready held low for 5 cycles during the second write beat -> beat held stable (data, mask, type=2); no double counting; completes after ready returns.
- rstn pulsed low during RD_RSP -> all outputs return to reset values asynchronously; a new port 1 request is granted after release.

Source files
------------

// File: rtl/ddr_fifo_arbiter.sv
// Two-port round-robin arbiter serializing burst read/write transactions into
// typed command beats for the DDR3 bridge FIFO port; one transaction in flight.
module ddr_fifo_arbiter #(
  parameter int ADDR_WIDTH = 27,
  parameter int BRST_WIDTH = 6,
  parameter int DATA_WIDTH = 128,
  parameter int MASK_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  calib_done,
  input  logic                  s0_req_valid,
  output logic                  s0_req_ready,
  input  logic                  s0_req_write,
  input  logic [ADDR_WIDTH-1:0] s0_req_addr,
  input  logic [BRST_WIDTH-1:0] s0_req_burst,
  input  logic                  s0_wvalid,
  output logic                  s0_wready,
  input  logic [DATA_WIDTH-1:0] s0_wdata,
  input  logic [MASK_WIDTH-1:0] s0_wmask,
  output logic                  s0_rvalid,
  input  logic                  s0_rready,
  output logic [DATA_WIDTH-1:0] s0_rdata,
  output logic                  s0_rlast,
  input  logic                  s1_req_valid,
  output logic                  s1_req_ready,
  input  logic                  s1_req_write,
  input  logic [ADDR_WIDTH-1:0] s1_req_addr,
  input  logic [BRST_WIDTH-1:0] s1_req_burst,
  input  logic                  s1_wvalid,
  output logic                  s1_wready,
  input  logic [DATA_WIDTH-1:0] s1_wdata,
  input  logic [MASK_WIDTH-1:0] s1_wmask,
  output logic                  s1_rvalid,
  input  logic                  s1_rready,
  output logic [DATA_WIDTH-1:0] s1_rdata,
  output logic                  s1_rlast,
  output logic                  m_cmd_valid,
  input  logic                  m_cmd_ready,
  output logic [1:0]            m_cmd_type,
  output logic [ADDR_WIDTH-1:0] m_cmd_addr,
  output logic [BRST_WIDTH-1:0] m_cmd_burst,
  output logic [DATA_WIDTH-1:0] m_cmd_wdata,
  output logic [MASK_WIDTH-1:0] m_cmd_wmask,
  input  logic                  m_rsp_valid,
  output logic                  m_rsp_ready,
  input  logic [DATA_WIDTH-1:0] m_rsp_data
);

  typedef enum logic [1:0] {IDLE, WR_BEAT, RD_CMD, RD_RSP} state_t;

  localparam logic [1:0] T_IDLE = 2'd0;
  localparam logic [1:0] T_CMD  = 2'd1;
  localparam logic [1:0] T_WT   = 2'd2;
  localparam logic [1:0] T_RD   = 2'd3;

  state_t                state_q, state_d;
  logic                  owner_q, owner_d;
  logic                  prio_q, prio_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [BRST_WIDTH-1:0] burst_q, burst_d;
  logic [BRST_WIDTH:0]   beat_q, beat_d;

  logic                  grant, accept, last, cmd_fire, rsp_fire;
  logic                  own_wvalid, own_rready;
  logic [DATA_WIDTH-1:0] own_wdata;
  logic [MASK_WIDTH-1:0] own_wmask;

  always_comb begin
    grant      = (s0_req_valid & s1_req_valid) ? prio_q : s1_req_valid;
    accept     = (state_q == IDLE) & calib_done & (s0_req_valid | s1_req_valid);
    own_wvalid = owner_q ? s1_wvalid : s0_wvalid;
    own_wdata  = owner_q ? s1_wdata  : s0_wdata;
    own_wmask  = owner_q ? s1_wmask  : s0_wmask;
    own_rready = owner_q ? s1_rready : s0_rready;
    // beat is one bit wider than burst so 64-beat bursts compare before wrapping
    last       = (beat_q == {1'b0, burst_q});
  end

  always_comb begin
    s0_req_ready = accept & ~grant;
    s1_req_ready = accept & grant;
    s0_wready    = 1'b0;
    s1_wready    = 1'b0;
    s0_rvalid    = 1'b0;
    s1_rvalid    = 1'b0;
    s0_rdata     = '0;
    s1_rdata     = '0;
    s0_rlast     = 1'b0;
    s1_rlast     = 1'b0;
    m_cmd_valid  = 1'b0;
    m_cmd_type   = T_IDLE;
    m_cmd_addr   = '0;
    m_cmd_burst  = '0;
    m_cmd_wdata  = '0;
    m_cmd_wmask  = '1;
    m_rsp_ready  = 1'b0;
    case (state_q)
      WR_BEAT: begin
        m_cmd_valid = own_wvalid;
        m_cmd_type  = (beat_q == '0) ? T_CMD : T_WT;
        m_cmd_addr  = addr_q;
        m_cmd_burst = burst_q;
        m_cmd_wdata = own_wdata;
        m_cmd_wmask = own_wmask;
        if (owner_q) s1_wready = m_cmd_ready;
        else         s0_wready = m_cmd_ready;
      end
      RD_CMD: begin
        m_cmd_valid = 1'b1;
        m_cmd_type  = T_RD;
        m_cmd_addr  = addr_q;
        m_cmd_burst = burst_q;
      end
      RD_RSP: begin
        m_rsp_ready = own_rready;
        if (owner_q) begin
          s1_rvalid = m_rsp_valid;
          s1_rdata  = m_rsp_data;
          s1_rlast  = last;
        end else begin
          s0_rvalid = m_rsp_valid;
          s0_rdata  = m_rsp_data;
          s0_rlast  = last;
        end
      end
      default: ;
    endcase

    cmd_fire = m_cmd_valid & m_cmd_ready;
    rsp_fire = m_rsp_valid & m_rsp_ready;

    state_d = state_q;
    owner_d = owner_q;
    prio_d  = prio_q;
    addr_d  = addr_q;
    burst_d = burst_q;
    beat_d  = beat_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          owner_d = grant;
          addr_d  = grant ? s1_req_addr  : s0_req_addr;
          burst_d = grant ? s1_req_burst : s0_req_burst;
          beat_d  = '0;
          state_d = (grant ? s1_req_write : s0_req_write) ? WR_BEAT : RD_CMD;
        end
      end
      WR_BEAT, RD_RSP: begin
        if ((state_q == WR_BEAT) ? cmd_fire : rsp_fire) begin
          beat_d = beat_q + 1'b1;
          if (last) begin
            state_d = IDLE;
            prio_d  = ~owner_q;
          end
        end
      end
      RD_CMD: begin
        if (cmd_fire) state_d = RD_RSP;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= IDLE;
      owner_q <= 1'b0;
      prio_q  <= 1'b0;
      addr_q  <= '0;
      burst_q <= '0;
      beat_q  <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      prio_q  <= prio_d;
      addr_q  <= addr_d;
      burst_q <= burst_d;
      beat_q  <= beat_d;
    end
  end

endmodule

// File: tb/tb_ddr_fifo_arbiter.sv
// Bench for ddr_fifo_arbiter: transaction-level model checked every cycle on the
// falling edge, plus directed scenarios with literal expectations.
module tb_ddr_fifo_arbiter;
  localparam int AW = 27;
  localparam int BW = 6;
  localparam int DW = 128;
  localparam int MW = 16;

  logic clk = 1'b0;
  logic rstn, calib_done;
  logic s0_req_valid, s0_req_ready, s0_req_write, s0_wvalid, s0_wready;
  logic s0_rvalid, s0_rready, s0_rlast;
  logic [AW-1:0] s0_req_addr;
  logic [BW-1:0] s0_req_burst;
  logic [DW-1:0] s0_wdata, s0_rdata;
  logic [MW-1:0] s0_wmask;
  logic s1_req_valid, s1_req_ready, s1_req_write, s1_wvalid, s1_wready;
  logic s1_rvalid, s1_rready, s1_rlast;
  logic [AW-1:0] s1_req_addr;
  logic [BW-1:0] s1_req_burst;
  logic [DW-1:0] s1_wdata, s1_rdata;
  logic [MW-1:0] s1_wmask;
  logic m_cmd_valid, m_cmd_ready, m_rsp_valid, m_rsp_ready;
  logic [1:0] m_cmd_type;
  logic [AW-1:0] m_cmd_addr;
  logic [BW-1:0] m_cmd_burst;
  logic [DW-1:0] m_cmd_wdata, m_rsp_data;
  logic [MW-1:0] m_cmd_wmask;

  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;
  logic [1:0] typ_q[$];

  ddr_fifo_arbiter #(.ADDR_WIDTH(AW), .BRST_WIDTH(BW), .DATA_WIDTH(DW), .MASK_WIDTH(MW)) dut (
    .clk(clk), .rstn(rstn), .calib_done(calib_done),
    .s0_req_valid(s0_req_valid), .s0_req_ready(s0_req_ready), .s0_req_write(s0_req_write),
    .s0_req_addr(s0_req_addr), .s0_req_burst(s0_req_burst),
    .s0_wvalid(s0_wvalid), .s0_wready(s0_wready), .s0_wdata(s0_wdata), .s0_wmask(s0_wmask),
    .s0_rvalid(s0_rvalid), .s0_rready(s0_rready), .s0_rdata(s0_rdata), .s0_rlast(s0_rlast),
    .s1_req_valid(s1_req_valid), .s1_req_ready(s1_req_ready), .s1_req_write(s1_req_write),
    .s1_req_addr(s1_req_addr), .s1_req_burst(s1_req_burst),
    .s1_wvalid(s1_wvalid), .s1_wready(s1_wready), .s1_wdata(s1_wdata), .s1_wmask(s1_wmask),
    .s1_rvalid(s1_rvalid), .s1_rready(s1_rready), .s1_rdata(s1_rdata), .s1_rlast(s1_rlast),
    .m_cmd_valid(m_cmd_valid), .m_cmd_ready(m_cmd_ready), .m_cmd_type(m_cmd_type),
    .m_cmd_addr(m_cmd_addr), .m_cmd_burst(m_cmd_burst), .m_cmd_wdata(m_cmd_wdata),
    .m_cmd_wmask(m_cmd_wmask), .m_rsp_valid(m_rsp_valid), .m_rsp_ready(m_rsp_ready),
    .m_rsp_data(m_rsp_data)
  );

  always #20 clk = ~clk;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [DW-1:0] wpat(input int p, input int k);
    return {8'(p + 1), 88'h0, 32'(k * 3 + 7)};
  endfunction

  function automatic logic [DW-1:0] rpat(input int k);
    return {32'hBEEF_0000 | 32'(k), 64'h0, 32'(k * 5 + 1)};
  endfunction

  // Transaction-level model: phase 0 idle, 1 writing, 2 read command, 3 read data.
  int   m_phase = 0;
  bit   m_port = 1'b0, m_prio = 1'b0;
  logic [AW-1:0] m_addr = '0;
  int   m_burst = 0, m_cnt = 0;

  always @(negedge clk) begin : cmp
    logic e_acc, e_g, e_cv, e_wr0, e_wr1, e_rv0, e_rv1, e_rl0, e_rl1, e_rspr, p_wv, p_rr;
    logic [1:0] e_type;
    logic [AW-1:0] e_addr;
    logic [BW-1:0] e_burst;
    logic [DW-1:0] e_wdata, e_rd0, e_rd1;
    logic [MW-1:0] e_wmask;
    if (!rstn) begin
      m_phase = 0; m_prio = 1'b0; m_port = 1'b0;
    end
    e_acc = (m_phase == 0) && calib_done && (s0_req_valid || s1_req_valid);
    e_g   = (s0_req_valid && s1_req_valid) ? m_prio : s1_req_valid;
    p_wv  = m_port ? s1_wvalid : s0_wvalid;
    p_rr  = m_port ? s1_rready : s0_rready;
    e_cv = 1'b0; e_type = 2'd0; e_addr = '0; e_burst = '0; e_wdata = '0; e_wmask = '1;
    e_wr0 = 1'b0; e_wr1 = 1'b0; e_rv0 = 1'b0; e_rv1 = 1'b0; e_rl0 = 1'b0; e_rl1 = 1'b0;
    e_rd0 = '0; e_rd1 = '0; e_rspr = 1'b0;
    case (m_phase)
      1: begin
        e_cv = p_wv; e_type = (m_cnt == 0) ? 2'd1 : 2'd2;
        e_addr = m_addr; e_burst = BW'(m_burst);
        e_wdata = m_port ? s1_wdata : s0_wdata;
        e_wmask = m_port ? s1_wmask : s0_wmask;
        if (m_port) e_wr1 = m_cmd_ready; else e_wr0 = m_cmd_ready;
      end
      2: begin
        e_cv = 1'b1; e_type = 2'd3; e_addr = m_addr; e_burst = BW'(m_burst);
      end
      3: begin
        e_rspr = p_rr;
        if (m_port) begin e_rv1 = m_rsp_valid; e_rd1 = m_rsp_data; e_rl1 = (m_cnt == m_burst); end
        else        begin e_rv0 = m_rsp_valid; e_rd0 = m_rsp_data; e_rl0 = (m_cnt == m_burst); end
      end
      default: ;
    endcase
    chk("s0_req_ready", 128'(s0_req_ready), 128'(e_acc && !e_g));
    chk("s1_req_ready", 128'(s1_req_ready), 128'(e_acc && e_g));
    chk("m_cmd_valid", 128'(m_cmd_valid), 128'(e_cv));
    chk("m_cmd_type", 128'(m_cmd_type), 128'(e_type));
    chk("m_cmd_addr", 128'(m_cmd_addr), 128'(e_addr));
    chk("m_cmd_burst", 128'(m_cmd_burst), 128'(e_burst));
    chk("m_cmd_wdata", m_cmd_wdata, e_wdata);
    chk("m_cmd_wmask", 128'(m_cmd_wmask), 128'(e_wmask));
    chk("s0_wready", 128'(s0_wready), 128'(e_wr0));
    chk("s1_wready", 128'(s1_wready), 128'(e_wr1));
    chk("m_rsp_ready", 128'(m_rsp_ready), 128'(e_rspr));
    chk("s0_rvalid", 128'(s0_rvalid), 128'(e_rv0));
    chk("s1_rvalid", 128'(s1_rvalid), 128'(e_rv1));
    chk("s0_rlast", 128'(s0_rlast), 128'(e_rl0));
    chk("s1_rlast", 128'(s1_rlast), 128'(e_rl1));
    chk("s0_rdata", s0_rdata, e_rd0);
    chk("s1_rdata", s1_rdata, e_rd1);
    if (rstn) begin
      case (m_phase)
        0: if (e_acc) begin
          m_port  = e_g;
          m_addr  = e_g ? s1_req_addr : s0_req_addr;
          m_burst = int'(e_g ? s1_req_burst : s0_req_burst);
          m_cnt   = 0;
          m_phase = (e_g ? s1_req_write : s0_req_write) ? 1 : 2;
        end
        1: if (p_wv && m_cmd_ready) begin
          m_cnt++;
          if (m_cnt > m_burst) begin m_phase = 0; m_prio = !m_port; end
        end
        2: if (m_cmd_ready) m_phase = 3;
        3: if (m_rsp_valid && p_rr) begin
          m_cnt++;
          if (m_cnt > m_burst) begin m_phase = 0; m_prio = !m_port; end
        end
        default: m_phase = 0;
      endcase
    end
  end

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic set_req(input int p, input bit v, input bit w, input logic [AW-1:0] a, input logic [BW-1:0] b);
    if (p == 0) begin s0_req_valid = v; s0_req_write = w; s0_req_addr = a; s0_req_burst = b; end
    else        begin s1_req_valid = v; s1_req_write = w; s1_req_addr = a; s1_req_burst = b; end
  endtask

  function automatic logic rdy(input int p);
    return (p == 0) ? s0_req_ready : s1_req_ready;
  endfunction

  task automatic wait_grant(input int p, output int n);
    bit ok = 1'b0;
    n = 0;
    while (!ok && n < 40) begin
      @(negedge clk); ok = rdy(p);
      step(); n++;
    end
    chk("grant_seen", 128'(ok), 128'(1));
    set_req(p, 1'b0, 1'b0, '0, '0);
  endtask

  task automatic do_write(input int p, input logic [AW-1:0] a, input int burst,
                          input int stall_beat, input int stall_cyc, output int wr_cycles);
    int k = 0, st = 0, n = 0, ng;
    bit fire, wr;
    typ_q.delete();
    if (p == 0) begin s0_wvalid = 1'b1; s0_wdata = wpat(p, 0); end
    else        begin s1_wvalid = 1'b1; s1_wdata = wpat(p, 0); end
    set_req(p, 1'b1, 1'b1, a, BW'(burst));
    wait_grant(p, ng);
    wr_cycles = 0;
    while (k <= burst && n < 300) begin
      if (p == 0) begin s0_wdata = wpat(p, k); s0_wmask = MW'(k + 1); end
      else        begin s1_wdata = wpat(p, k); s1_wmask = MW'(k + 1); end
      m_cmd_ready = (k == stall_beat && st < stall_cyc) ? 1'b0 : 1'b1;
      @(negedge clk);
      wr = (p == 0) ? s0_wready : s1_wready;
      fire = wr && m_cmd_valid;
      if (wr) wr_cycles++;
      if (!m_cmd_ready) begin
        st++;
        chk("stall_type", 128'(m_cmd_type), 128'(2));
        chk("stall_data", m_cmd_wdata, wpat(p, 1));
        chk("stall_mask", 128'(m_cmd_wmask), 128'(2));
      end
      if (fire) typ_q.push_back(m_cmd_type);
      step(); n++;
      if (fire) k++;
    end
    chk("wr_beats", 128'(k), 128'(burst + 1));
    chk("wr_type_cnt", 128'(typ_q.size()), 128'(burst + 1));
    for (int i = 0; i < typ_q.size(); i++)
      chk("wr_type_seq", 128'(typ_q[i]), 128'((i == 0) ? 1 : 2));
    if (p == 0) s0_wvalid = 1'b0; else s1_wvalid = 1'b0;
    m_cmd_ready = 1'b1;
  endtask

  task automatic do_read(input int p, input logic [AW-1:0] a, input int burst,
                         input bit throttle, input int calib_hold);
    int k = 0, n = 0, rl = 0, ng;
    bit fire;
    if (calib_hold > 0) calib_done = 1'b0;
    set_req(p, 1'b1, 1'b0, a, BW'(burst));
    for (int i = 0; i < calib_hold; i++) begin
      @(negedge clk); chk("calib_block", 128'(rdy(p)), 128'(0));
      step();
    end
    calib_done = 1'b1;
    wait_grant(p, ng);
    if (calib_hold > 0) chk("calib_grant_cycle", 128'(ng), 128'(1));
    while (k <= burst && n < 600) begin
      m_rsp_valid = throttle ? ((n % 3) != 1) : 1'b1;
      m_rsp_data  = rpat(k);
      if (p == 0) s0_rready = throttle ? ((n % 4) != 2) : 1'b1;
      else        s1_rready = throttle ? ((n % 4) != 2) : 1'b1;
      @(negedge clk);
      fire = (p == 0) ? (s0_rvalid && s0_rready) : (s1_rvalid && s1_rready);
      if (fire) begin
        chk("rd_data", (p == 0) ? s0_rdata : s1_rdata, rpat(k));
        if ((p == 0) ? s0_rlast : s1_rlast) begin
          rl++;
          chk("rlast_pos", 128'(k), 128'(burst));
        end
      end
      step(); n++;
      if (fire) k++;
    end
    chk("rd_beats", 128'(k), 128'(burst + 1));
    chk("rlast_cnt", 128'(rl), 128'(1));
    m_rsp_valid = 1'b0; s0_rready = 1'b0; s1_rready = 1'b0;
  endtask

  // Both ports request single-beat reads together; grant order must start at 'first'.
  task automatic serve_both(input int first);
    int gq[$];
    int rq[$];
    int n = 0;
    bit g0, g1, f0, f1;
    set_req(0, 1'b1, 1'b0, 27'h0a0, '0);
    set_req(1, 1'b1, 1'b0, 27'h1b0, '0);
    m_rsp_valid = 1'b1; m_rsp_data = rpat(9); s0_rready = 1'b1; s1_rready = 1'b1;
    while (rq.size() < 2 && n < 40) begin
      @(negedge clk);
      g0 = s0_req_ready; g1 = s1_req_ready;
      f0 = s0_rvalid && s0_rready; f1 = s1_rvalid && s1_rready;
      if (g0) gq.push_back(0);
      if (g1) gq.push_back(1);
      if (f0) begin rq.push_back(0); chk("both_rlast0", 128'(s0_rlast), 128'(1)); end
      if (f1) begin rq.push_back(1); chk("both_rlast1", 128'(s1_rlast), 128'(1)); end
      step(); n++;
      if (g0) s0_req_valid = 1'b0;
      if (g1) s1_req_valid = 1'b0;
    end
    chk("both_grants", 128'(gq.size()), 128'(2));
    chk("both_rsps", 128'(rq.size()), 128'(2));
    if (gq.size() == 2) begin
      chk("grant_first", 128'(gq[0]), 128'(first));
      chk("grant_second", 128'(gq[1]), 128'(1 - first));
    end
    if (rq.size() == 2) chk("rsp_first", 128'(rq[0]), 128'(first));
    set_req(0, 1'b0, 1'b0, '0, '0);
    set_req(1, 1'b0, 1'b0, '0, '0);
    m_rsp_valid = 1'b0; s0_rready = 1'b0; s1_rready = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int wc, ng;
    rstn = 1'b0; calib_done = 1'b1;
    set_req(0, 1'b0, 1'b0, '0, '0);
    set_req(1, 1'b0, 1'b0, '0, '0);
    s0_wvalid = 1'b0; s0_wdata = '0; s0_wmask = '0; s0_rready = 1'b0;
    s1_wvalid = 1'b0; s1_wdata = '0; s1_wmask = '0; s1_rready = 1'b0;
    m_cmd_ready = 1'b1; m_rsp_valid = 1'b0; m_rsp_data = '0;
    #1;
    chk("rst_cmd_valid", 128'(m_cmd_valid), 128'(0));
    chk("rst_cmd_wmask", 128'(m_cmd_wmask), 128'(16'hffff));
    chk("rst_cmd_type", 128'(m_cmd_type), 128'(0));
    repeat (2) @(posedge clk);
    #7 rstn = 1'b1;
    step();

    serve_both(0);

    do_write(0, 27'h100, 3, -1, 0, wc);
    chk("wr_wready_cycles", 128'(wc), 128'(4));

    serve_both(1);

    do_read(1, 27'h2000, 63, 1'b1, 0);

    do_read(0, 27'h300, 0, 1'b0, 10);

    do_write(1, 27'h440, 3, 1, 5, wc);
    chk("stall_wready_cycles", 128'(wc), 128'(4));

    // Reset pulse while port 0 read responses are flowing.
    set_req(0, 1'b1, 1'b0, 27'h500, 6'd7);
    wait_grant(0, ng);
    m_rsp_valid = 1'b1; m_rsp_data = rpat(3); s0_rready = 1'b1;
    step(); step();
    chk("pre_rst_rvalid", 128'(s0_rvalid), 128'(1));
    #5 rstn = 1'b0;
    #1;
    chk("arst_rvalid", 128'(s0_rvalid), 128'(0));
    chk("arst_rsp_ready", 128'(m_rsp_ready), 128'(0));
    chk("arst_rdata", s0_rdata, '0);
    chk("arst_cmd_wmask", 128'(m_cmd_wmask), 128'(16'hffff));
    chk("arst_cmd_valid", 128'(m_cmd_valid), 128'(0));
    repeat (2) @(posedge clk);
    #10 rstn = 1'b1;
    m_rsp_valid = 1'b0; s0_rready = 1'b0;
    step();
    do_read(1, 27'h600, 1, 1'b0, 0);

    step(); step();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
